systolic_result_axis_tx: RTL
============================

// Module: systolic_result_axis_tx
// PURPOSE
//  AXI-Stream transmitter for systolic-array results; the send-side counterpart of the input matrix buffer.
//  Collects one N x N result tile as N row beats of N parallel words.
//  Emits the tile row-major on an AXIS master with TLAST on the final word, honouring TREADY backpressure.
//  Two-bank ping-pong storage: one tile can drain while the next is captured.
//  Sits between the accumulate stage and the DMA S2MM port.
// PARAMETERS
//  DATA_W   32   width of one result word and of m_axis_data
//  N        4    tile dimension; tile = N*N words, N row beats (N power of 2, >=2)
// PORTS
//  axi_clk        in   1         single clock; all logic rising-edge
//  axi_rst        in   1         asynchronous, active-low reset
//  s_data         in   N*DATA_W  one result row; lane k = bits [k*DATA_W +: DATA_W] = column k
//  s_valid        in   1         row beat valid
//  s_ready        out  1         row beat accepted when s_valid & s_ready
//  m_axis_data    out  DATA_W    output word
//  m_axis_valid   out  1         output word valid
//  m_axis_ready   in   1         downstream ready
//  m_axis_last    out  1         high with word N*N-1 of each tile
//  o_intr         out  1         one-cycle pulse when a tile's last word handshakes
//  o_tile_count   out  16        number of tiles fully sent, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (axi_rst=0, async): both banks empty.
//   Write bank, read bank, row counter and word counter = 0.
//   Outputs: s_ready=0 while in reset, then 1; m_axis_valid=0, m_axis_last=0, o_intr=0, o_tile_count=0.
//   m_axis_data=0 while m_axis_valid=0.
//  Storage: 2 banks x N*N x DATA_W registers; per-bank full flag.
//  Write side:
//   - s_ready = !full[wr_bank].
//   - On an accepted beat, the row is stored at row wr_row of wr_bank, and wr_row increments.
//   - Accepting row N-1 sets full[wr_bank], toggles wr_bank and clears wr_row.
//  Read side:
//   - m_axis_valid = full[rd_bank].
//   - m_axis_data = word rd_word of rd_bank, row-major: word r*N+c = row r, lane c.
//   - m_axis_last = m_axis_valid & (rd_word == N*N-1).
//   - On handshake (valid & ready), rd_word increments.
//   - Handshake on the last word: clears full[rd_bank], toggles rd_bank, clears rd_word.
//     The same edge pulses o_intr and increments o_tile_count.
//  Latency: the first word of a tile is valid the cycle after its last row is accepted (bank full flag registered).
//   With m_axis_ready held high, a tile drains in N*N cycles with no bubbles.
//   Back-to-back full tiles stream with no gap between TLAST and the next first word.
//  AXIS rules:
//   - Once m_axis_valid=1, data/last hold stable until handshake.
//   - valid never depends on m_axis_ready.
//  Simultaneous events:
//   - Last-word read handshake and a write into the same bank on the same edge cannot occur, because the write needs !full.
//   - Last read of bank A with last row write of bank B on the same edge: full[A] clears, full[B] sets, and bank B is presented next cycle.
//   - s_ready reflects full at cycle start. A freed bank is writable from the next cycle (no combinational ready path).
//  Boundary: with both banks full, s_ready=0 and the upstream stalls; no beat is dropped or overwritten.
//   A partial tile (fewer than N rows) is never transmitted.
//  Reset mid-operation: the partial tile and any undrained tile are discarded and all state returns to reset values.
//   The next tile starts at bank 0, word 0.
// TESTING
//  1. Reset, then 4 rows {0,1,2,3},{4..7},{8..11},{12..15} with ready=1 -> words 0..15 on 16 consecutive cycles from row4+1; last on 15; o_intr once; count=1.
//  2. Same tile, m_axis_ready toggling 1-0-1-0 -> data/last stable during stalls; 16 handshakes; order 0..15.
//  3. m_axis_ready=0, push 3 tiles back-to-back -> s_ready drops after the 8th row; the 9th row is held; release -> tiles 1,2,3 in order, count=3.
//  4. Continuous input plus ready=1 for 4 tiles -> no idle cycle between tiles on m_axis; o_intr at cycles 16, 32, 48 and 64 after first valid.
//  5. Reset asserted after 2 rows, and again mid-drain at word 7 -> all outputs 0 immediately; a fresh tile afterwards starts at word 0; count=0.
//  6. o_tile_count preloaded via 65535 tiles (or forced) -> the next tile wraps it to 0.

Source files
------------

// File: rtl/systolic_result_axis_tx.sv
// rtl/systolic_result_axis_tx.sv - ping-pong tile buffer draining N x N results row-major onto an AXIS master
//
// Purpose: captures one N x N result tile as N row beats of N words, then
// streams it word by word (row-major) with TLAST on the final word. Two banks
// let the next tile be captured while the current one drains.
//
// Ports:
//   axi_clk       clock, all logic on the rising edge
//   axi_rst       asynchronous active-low reset
//   s_data        one result row, lane k = column k
//   s_valid       row beat valid
//   s_ready       row beat accepted when s_valid & s_ready
//   m_axis_data   output word (0 while m_axis_valid is low)
//   m_axis_valid  output word valid
//   m_axis_ready  downstream ready
//   m_axis_last   high with the last word of each tile
//   o_intr        one-cycle pulse after a tile's last word handshakes
//   o_tile_count  tiles fully sent, wraps at 16 bits

module systolic_result_axis_tx #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic [N*DATA_W-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_W-1:0]     m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  o_intr,
  output logic [15:0]           o_tile_count
);

  localparam int WORDS = N * N;
  localparam int RW    = $clog2(N);
  localparam int WW    = $clog2(WORDS);

  logic [DATA_W-1:0] r_mem [2][WORDS];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [RW-1:0]     r_wr_row;
  logic [WW-1:0]     r_rd_word;
  logic              r_intr;
  logic [15:0]       r_tile_count;
  // Low during reset and for the first edge after it, so s_ready stays low
  // while the block is held in reset.
  logic              r_run;

  logic              w_wr_en;
  logic              w_rd_hs;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;

  assign s_ready      = r_run & ~r_full[r_wr_bank];
  assign m_axis_valid = r_full[r_rd_bank];
  assign m_axis_data  = m_axis_valid ? r_mem[r_rd_bank][r_rd_word] : '0;
  assign m_axis_last  = m_axis_valid & (r_rd_word == WW'(WORDS - 1));
  assign o_intr       = r_intr;
  assign o_tile_count = r_tile_count;

  assign w_wr_en   = s_valid & s_ready;
  assign w_rd_hs   = m_axis_valid & m_axis_ready;
  assign w_wr_last = w_wr_en & (r_wr_row == RW'(N - 1));
  assign w_rd_last = w_rd_hs & m_axis_last;

  // A bank being written is never full and a bank being read always is, so
  // the set and clear masks never target the same bank on one edge.
  assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      r_run        <= 1'b0;
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_row     <= '0;
      r_rd_word    <= '0;
      r_intr       <= 1'b0;
      r_tile_count <= 16'd0;
    end else begin
      r_run  <= 1'b1;
      r_full <= (r_full & ~w_full_clr) | w_full_set;
      r_intr <= w_rd_last;

      if (w_wr_en) begin
        if (w_wr_last) begin
          r_wr_row  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row <= r_wr_row + 1'b1;
        end
      end

      if (w_rd_hs) begin
        if (w_rd_last) begin
          r_rd_word    <= '0;
          r_rd_bank    <= ~r_rd_bank;
          r_tile_count <= r_tile_count + 16'd1;
        end else begin
          r_rd_word <= r_rd_word + 1'b1;
        end
      end
    end
  end

  // Tile storage carries no reset; the full flags alone decide what is valid.
  always_ff @(posedge axi_clk) begin
    if (w_wr_en) begin
      for (int c = 0; c < N; c++) begin
        r_mem[r_wr_bank][{r_wr_row, RW'(c)}] <= s_data[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule
